// File: rtl/cluster_soc_evt_queue.sv
// ---------------------------------------------------------------------------
// cluster_soc_evt_queue
//
// Buffers fire-and-forget SoC peripheral event IDs for the cluster event
// unit. Events are queued in a FIFO and offered downstream with a
// valid/ready handshake. Events arriving while the FIFO is full (and no pop
// frees a slot in the same cycle) are dropped. Drops are reported through a
// sticky overflow flag and a saturating drop counter.
//
// Ports:
//   clk_i            cluster clock
//   rst_ni           asynchronous active-low reset
//   soc_evt_valid_i  one-cycle strobe: event presented this cycle
//   soc_evt_data_i   event ID, sampled when soc_evt_valid_i=1
//   evt_valid_o      head entry valid (FIFO not empty)
//   evt_ready_i      downstream accepts the head entry
//   evt_data_o       head entry ID
//   clr_i            one-cycle strobe: clears overflow flag and drop counter
//   overflow_o       sticky: at least one event dropped since reset/clear
//   drop_cnt_o       saturating count of dropped events
//   level_o          current FIFO occupancy
// ---------------------------------------------------------------------------
module cluster_soc_evt_queue #(
    parameter int EVNT_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       soc_evt_valid_i,
    input  logic [EVNT_WIDTH-1:0]      soc_evt_data_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [EVNT_WIDTH-1:0]      evt_data_o,
    input  logic                       clr_i,
    output logic                       overflow_o,
    output logic [CNT_WIDTH-1:0]       drop_cnt_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [EVNT_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  overflow_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic push_acc;
    logic drop;

    assign push  = soc_evt_valid_i;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign pop   = evt_valid_o & evt_ready_i;

    // A pop frees the head slot in the same cycle, so a push into a full
    // FIFO is still accepted when the head leaves at the same edge.
    assign push_acc = push & (~full | pop);
    assign drop     = push & full & ~pop;

    assign evt_valid_o = ~empty;
    assign evt_data_o  = mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

    // Storage array. When full with a simultaneous pop, the write pointer
    // equals the read pointer; the old head is read combinationally before
    // the edge, so overwriting it here is safe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_acc) begin
            mem_q[wr_ptr_q] <= soc_evt_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
        end else if (push_acc && !pop) begin
            level_q <= level_q + LVL_W'(1);
        end else if (pop && !push_acc) begin
            level_q <= level_q - LVL_W'(1);
        end
    end

    // A drop in the same cycle as a clear takes priority: the flag stays set
    // and the counter restarts at one, so the new loss is not hidden.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clr_i) begin
                drop_cnt_q <= CNT_WIDTH'(1);
            end else if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
        end else if (clr_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

endmodule
